// File: rtl/keypad_uart_transmit.sv
// keypad_uart_transmit: 4-digit keypad entry buffer plus UART sender of the buffer as ASCII "dddd\r" (8N1; 8E1 with TX_PARITY_EN).
// Latency: start bit of byte 0 begins one cycle after an accepted submit; frame lasts 50*DIV cycles (55*DIV with TX_PARITY_EN).
// Backpressure: submit while busy is dropped silently (no queueing); digit entry and clear are never blocked.
module keypad_uart_transmit #(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 9600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] num,
  input  logic       numPressed,
  input  logic       clear,
  input  logic       submit,
  output logic [3:0] num1,
  output logic [3:0] num2,
  output logic [3:0] num3,
  output logic [3:0] num4,
  output logic       txd,
  output logic       busy,
  output logic       done
);

  localparam int DIV = CLK_FREQ / BAUD;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST     = CW'(DIV - 1);
  localparam logic [CW-1:0] PRE_LAST = CW'(DIV - 2);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t          state;
  logic [4:0][7:0] frame;     // snapshot taken at submit; frame[0] goes out first
  logic [2:0]      byte_idx;
  logic [2:0]      bit_idx;
  logic [CW-1:0]   baud_cnt;
  logic            bit_end;
  logic [7:0]      cur_byte;

  assign bit_end  = (baud_cnt == LAST);
  assign cur_byte = frame[byte_idx];

  // Entry buffer: clear wins over a digit; digits above 9 are ignored; busy does not block entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      num1 <= 4'd0;
      num2 <= 4'd0;
      num3 <= 4'd0;
      num4 <= 4'd0;
    end else if (clear) begin
      num1 <= 4'd0;
      num2 <= 4'd0;
      num3 <= 4'd0;
      num4 <= 4'd0;
    end else if (numPressed && (num <= 4'd9)) begin
      num1 <= num2;
      num2 <= num3;
      num3 <= num4;
      num4 <= num;
    end
  end

  // Transmit FSM: registered txd/busy/done, baud counter held at 0 in IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      frame    <= '0;
      byte_idx <= 3'd0;
      bit_idx  <= 3'd0;
      baud_cnt <= '0;
      txd      <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state != IDLE) begin
        baud_cnt <= bit_end ? '0 : baud_cnt + 1'b1;
      end
      case (state)
        IDLE: begin
          txd      <= 1'b1;
          busy     <= 1'b0;
          baud_cnt <= '0;
          if (submit) begin
            // Snapshot uses the buffer as it stands before any same-cycle edit.
            frame    <= {8'h0D, 8'h30 + {4'h0, num4}, 8'h30 + {4'h0, num3},
                         8'h30 + {4'h0, num2}, 8'h30 + {4'h0, num1}};
            state    <= START;
            txd      <= 1'b0;
            busy     <= 1'b1;
            byte_idx <= 3'd0;
            bit_idx  <= 3'd0;
          end
        end
        START: begin
          if (bit_end) begin
            state   <= DATA;
            bit_idx <= 3'd0;
            txd     <= cur_byte[0];
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_idx == 3'd7) begin
`ifdef TX_PARITY_EN
              state <= PARITY;
              txd   <= ^cur_byte;
`else
              state <= STOP;
              txd   <= 1'b1;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
              txd     <= cur_byte[bit_idx + 3'd1];
            end
          end
        end
`ifdef TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            state <= STOP;
            txd   <= 1'b1;
          end
        end
`endif
        STOP: begin
          // done is registered, so raise it one cycle early to land in the last stop cycle.
          if ((baud_cnt == PRE_LAST) && (byte_idx == 3'd4)) begin
            done <= 1'b1;
          end
          if (bit_end) begin
            if (byte_idx != 3'd4) begin
              byte_idx <= byte_idx + 3'd1;
              state    <= START;
              txd      <= 1'b0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
              txd   <= 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          txd   <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_uart_transmit.sv
// tb_keypad_uart_transmit: directed stimulus with a scoreboard of expected bytes and a UART receive monitor.
// Latency: checks start-bit latency of one cycle and done at 50*DIV (55*DIV with TX_PARITY_EN) cycles after submit.
// Backpressure: exercises dropped submit while busy and digit entry during a frame.
module tb_keypad_uart_transmit;

  localparam int DIV = 16;
`ifdef TX_PARITY_EN
  localparam int FRAME = 55 * DIV;
`else
  localparam int FRAME = 50 * DIV;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] num;
  logic       numPressed;
  logic       clear;
  logic       submit;
  logic [3:0] num1, num2, num3, num4;
  logic       txd;
  logic       busy;
  logic       done;

  int tests = 0;
  int fails = 0;
  int rx_count = 0;
  bit mon_skip = 1'b0;
  logic [7:0] exp_q[$];

  logic [7:0] mon_d;
  logic [7:0] mon_exp;
  logic       mon_sb, mon_stb, mon_pb;
  logic       mon_ok;

  keypad_uart_transmit #(.CLK_FREQ(16), .BAUD(1)) dut (
    .clk(clk), .reset(reset), .num(num), .numPressed(numPressed),
    .clear(clear), .submit(submit), .num1(num1), .num2(num2),
    .num3(num3), .num4(num4), .txd(txd), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_buf(input string name, input logic [15:0] exp);
    chk(name, int'({num1, num2, num3, num4}), int'(exp));
  endtask

  task automatic press(input logic [3:0] d);
    @(negedge clk);
    numPressed = 1'b1;
    num = d;
    @(negedge clk);
    numPressed = 1'b0;
  endtask

  // mode 0: plain; mode 1: resubmit at cycle 100 and digit 9 at cycle 200; mode 2: digit 6 with submit
  task automatic run_frame(input logic [3:0] d1, d2, d3, d4, input int mode);
    int cnt;
    int rx0;
    bit got;
    exp_q.push_back(8'h30 + {4'h0, d1});
    exp_q.push_back(8'h30 + {4'h0, d2});
    exp_q.push_back(8'h30 + {4'h0, d3});
    exp_q.push_back(8'h30 + {4'h0, d4});
    exp_q.push_back(8'h0D);
    rx0 = rx_count;
    @(negedge clk);
    submit = 1'b1;
    if (mode == 2) begin
      numPressed = 1'b1;
      num = 4'd6;
    end
    cnt = 0;
    got = 1'b0;
    while (cnt < 2000 && !got) begin
      @(negedge clk);
      cnt++;
      submit = 1'b0;
      numPressed = 1'b0;
      if (cnt == 1) begin
        chk("latency_txd", int'(txd), 0);
        chk("latency_busy", int'(busy), 1);
      end
      if (mode == 1 && cnt == 100) submit = 1'b1;
      if (mode == 1 && cnt == 200) begin
        numPressed = 1'b1;
        num = 4'd9;
      end
      if (done) got = 1'b1;
    end
    chk("done_cycle", cnt, FRAME);
    chk("busy_at_done", int'(busy), 1);
    @(negedge clk);
    chk("busy_after_done", int'(busy), 0);
    chk("done_pulse_width", int'(done), 0);
    repeat (300) @(negedge clk);
    chk("bytes_received", rx_count - rx0, 5);
    chk("scoreboard_empty", exp_q.size(), 0);
  endtask

  // Monitor: decode each UART character from txd and compare with the scoreboard head.
  initial begin
    forever begin
      @(negedge clk);
      if (txd === 1'b0 && reset === 1'b0) begin
        repeat (DIV / 2) @(negedge clk);
        mon_sb = txd;
        for (int i = 0; i < 8; i++) begin
          repeat (DIV) @(negedge clk);
          mon_d[i] = txd;
        end
        mon_pb = 1'b0;
`ifdef TX_PARITY_EN
        repeat (DIV) @(negedge clk);
        mon_pb = txd;
`endif
        repeat (DIV) @(negedge clk);
        mon_stb = txd;
        if (!mon_skip) begin
          rx_count++;
          tests++;
          if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL rx_unexpected: got byte %02h expected none", mon_d);
          end else begin
            mon_exp = exp_q.pop_front();
            mon_ok = (mon_sb == 1'b0) && (mon_d == mon_exp) && (mon_stb == 1'b1);
`ifdef TX_PARITY_EN
            mon_ok = mon_ok && (mon_pb == ^mon_exp);
`endif
            if (!mon_ok) begin
              fails++;
              $display("FAIL rx_byte: got data %02h start %0b stop %0b parity %0b expected data %02h start 0 stop 1 parity %0b",
                       mon_d, mon_sb, mon_stb, mon_pb, mon_exp, ^mon_exp);
            end
          end
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    num = 4'd0;
    numPressed = 1'b0;
    clear = 1'b0;
    submit = 1'b0;
    repeat (3) @(negedge clk);
    chk_buf("reset_buf", 16'h0000);
    chk("reset_txd", int'(txd), 1);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    reset = 1'b0;

    // Digit entry and a full frame
    press(4'd1);
    press(4'd2);
    press(4'd3);
    press(4'd4);
    chk_buf("entry_1234", 16'h1234);
    run_frame(4'd1, 4'd2, 4'd3, 4'd4, 0);

    // Input filtering
    press(4'd11);
    chk_buf("ignore_11", 16'h1234);
    @(negedge clk);
    clear = 1'b1;
    numPressed = 1'b1;
    num = 4'd7;
    @(negedge clk);
    clear = 1'b0;
    numPressed = 1'b0;
    chk_buf("clear_priority", 16'h0000);

    // Busy handling: resubmit dropped, entry during frame
    run_frame(4'd0, 4'd0, 4'd0, 4'd0, 1);
    chk_buf("entry_during_frame", 16'h0009);

    // Snapshot timing with same-cycle digit
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    press(4'd5);
    chk_buf("entry_0005", 16'h0005);
    run_frame(4'd0, 4'd0, 4'd0, 4'd5, 2);
    chk_buf("snapshot_buf", 16'h0056);

    // Parity pattern: 0x31 and 0x30 bytes
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    press(4'd1);
    run_frame(4'd0, 4'd0, 4'd0, 4'd1, 0);

    // Reset mid-frame
    @(negedge clk);
    submit = 1'b1;
    @(negedge clk);
    submit = 1'b0;
    repeat (100) @(negedge clk);
    chk("midframe_busy", int'(busy), 1);
    mon_skip = 1'b1;
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("abort_txd", int'(txd), 1);
    chk("abort_busy", int'(busy), 0);
    chk_buf("abort_buf", 16'h0000);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (200) @(negedge clk);
    chk("post_abort_busy", int'(busy), 0);
    chk("post_abort_txd", int'(txd), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/keypad_uart_transmit.md
Name: keypad_uart_transmit

Overview:
Transmit end of the keypad-to-UART link; the receive end is already in the design. It collects decimal digits from the keyboard decoder into a 4-digit entry buffer and exposes that buffer for the digital LED display. On submit, it serialises the buffer over txd as ASCII text, using 8N1 UART LSB-first. The receiving calculator parses this frame.

Parameters:
CLK_FREQ, 50000000, system clock frequency in Hz
BAUD, 9600, line rate in bit/s; bit period DIV = CLK_FREQ/BAUD cycles (integer divide, DIV >= 2)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-high reset
num  input  4  digit from keyboard decoder, valid when numPressed=1
numPressed  input  1  one-cycle pulse: new digit available
clear  input  1  one-cycle pulse: zero entry buffer
submit  input  1  one-cycle pulse: send current buffer
num1  output  4  entry buffer, most significant digit
num2  output  4  entry buffer digit 2
num3  output  4  entry buffer digit 3
num4  output  4  entry buffer, least significant digit
txd  output  1  UART serial out, idle high
busy  output  1  high from the cycle after an accepted submit until the last stop bit completes
done  output  1  one-cycle pulse in the final cycle of the last stop bit

Behaviour:
- Reset: num1..num4=0, txd=1, busy=0, done=0, FSM=IDLE, all counters 0. Reset asserted mid-frame aborts the frame; txd returns high asynchronously.
- Entry buffer:
  - numPressed with num<=9 shifts left: num1<=num2, num2<=num3, num3<=num4, num4<=num.
  - numPressed with num>9 is ignored.
  - clear zeroes all four digits and has priority over numPressed in the same cycle.
  - The buffer is updated regardless of busy.
- Submit acceptance:
  - submit is accepted only when busy=0; submit while busy is dropped silently with no queueing.
  - On acceptance, the 5-byte frame is snapshotted from the pre-update buffer: 0x30+num1, 0x30+num2, 0x30+num3, 0x30+num4, 0x0D.
  - A same-cycle numPressed or clear affects the buffer but not the snapshot.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: txd=1. An accepted submit moves to START the next cycle with byte index=0.
  - START: txd=0 for DIV cycles, then DATA with bit index=0.
  - DATA: txd=byte[bit index] for DIV cycles per bit, LSB first. After bit 7, go to STOP.
  - STOP: txd=1 for DIV cycles. If byte index<4, increment it and go to START. Otherwise pulse done in the final STOP cycle, then return to IDLE.
- Bytes are sent back to back with no idle gap between them.
- Frame length: 50*DIV cycles.
- Latency: the start bit of byte 0 begins exactly one cycle after the submit edge.
- busy=1 in every non-IDLE cycle. busy drops in the cycle after done.
- A new submit is accepted in the cycle busy=0.
- The baud counter counts 0..DIV-1 and reloads at each bit boundary. It is held at 0 in IDLE.
- txd is driven from a register (glitch-free).

Optional Feature:
Macro TX_PARITY_EN.
- Defined: frames are 8E1. After bit 7 of DATA, a PARITY state drives the XOR of the 8 data bits for DIV cycles, then enters STOP. Frame length becomes 55*DIV cycles.
- Undefined: 8N1 as above; no PARITY state exists.

Test Plan:
- Run all scenarios with CLK_FREQ=16, BAUD=1 (DIV=16) unless noted.
- Reset: assert reset mid-frame -> txd=1, busy=0, num1..num4=0 in the same cycle.
- Digit entry and submit: enter 1,2,3,4, then submit -> num1..4=1,2,3,4.
  - txd carries 0x31,0x32,0x33,0x34,0x0D LSB first, each framed by start 0 and stop 1.
  - Each bit lasts 16 cycles; done occurs at cycle 800 after submit.
- Input filtering: numPressed with num=11 -> buffer unchanged. clear and numPressed(7) in the same cycle -> buffer 0,0,0,0.
- Busy handling: submit again 100 cycles into a frame -> ignored, and exactly 5 bytes go out.
  - Enter digit 9 during the frame -> num4=9, while the frame still carries the old snapshot.
- Snapshot timing: submit with 0,0,0,5 and numPressed(6) in the same cycle -> frame carries "0005\r"; buffer becomes 0,0,5,6.
- Parity (TX_PARITY_EN defined): buffer 0,0,0,1 -> byte 0x31 sends parity 1, byte 0x30 sends parity 0; frame length is 880 cycles.
